// File: rtl/commit_unit.sv
// In-order commit stage: registers the register-file write, queues committed stores toward the LSB,
// and raises a one-cycle flush/redirect on a mispredicted control transfer, then ignores commits briefly.
`ifndef COMMIT_UNIT_DEFS
`define COMMIT_UNIT_DEFS
`define InstrIdWidth 6
`define RegIdxWidth  5
`define ROBIdxWidth  4
`define LSBIdxWidth  4
`define WordWidth    32
`define AddrWidth    32
`define JAL   6'd3
`define JALR  6'd4
`define BEQ   6'd5
`define BNE   6'd6
`define BLT   6'd7
`define BGE   6'd8
`define BLTU  6'd9
`define BGEU  6'd10
`define SB    6'd16
`define SH    6'd17
`define SW    6'd18
`define ADDI  6'd19
`define ADD   6'd28
`endif

module commit_unit #(
  parameter int STQ_DEPTH    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      rob_to_commit_en_in,
  input  logic [`InstrIdWidth-1:0]  instr_id_in,
  input  logic [`RegIdxWidth-1:0]   rd_in,
  input  logic [`ROBIdxWidth-1:0]   rob_pos_in,
  input  logic [`LSBIdxWidth-1:0]   lsb_pos_in,
  input  logic [`WordWidth-1:0]     res_in,
  input  logic                      jump_en_in,
  input  logic [`AddrWidth-1:0]     jump_a_in,
  output logic                      reg_wr_en_out,
  output logic [`RegIdxWidth-1:0]   reg_wr_rd_out,
  output logic [`WordWidth-1:0]     reg_wr_data_out,
  output logic [`ROBIdxWidth-1:0]   reg_wr_rob_pos_out,
  output logic                      store_commit_valid_out,
  output logic [`LSBIdxWidth-1:0]   store_commit_lsb_pos_out,
  input  logic                      lsb_store_ready_in,
  output logic                      clear_branch_out,
  output logic                      pc_redirect_en_out,
  output logic [`AddrWidth-1:0]     pc_redirect_a_out,
  output logic                      stq_almost_full_out,
  output logic                      stq_overflow_out,
  output logic [31:0]               retire_cnt_out,
  output logic                      state_dbg_out
);

  localparam int PW = $clog2(STQ_DEPTH);
  localparam int CW = $clog2(STQ_DEPTH + 1);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic            accept;
  logic            is_store, is_branch, wr_req;

  logic [`LSBIdxWidth-1:0] stq_mem [STQ_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            stq_full, stq_pop, stq_push_req, stq_push;

  assign is_store  = (instr_id_in == `SB) || (instr_id_in == `SH) || (instr_id_in == `SW);
  assign is_branch = (instr_id_in >= `BEQ) && (instr_id_in <= `BGEU);
  assign wr_req    = accept && (rd_in != '0) && !is_store && !is_branch;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    accept      = 1'b0;
    case (state_q)
      RUN: begin
        accept = rdy_in && rob_to_commit_en_in;
        if (accept && jump_en_in) begin
          state_d     = FLUSH;
          flush_cnt_d = FW'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        // Leaving on the decrement to zero makes exactly FLUSH_CYCLES commit slots ignored.
        if (flush_cnt_q <= FW'(1)) begin
          flush_cnt_d = '0;
          state_d     = RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - FW'(1);
        end
      end
      default: begin
        state_d     = RUN;
        flush_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state_dbg_out = (state_q == FLUSH);

  // Store handshake: an entry leaves when store_commit_valid_out and lsb_store_ready_in are both
  // high on a rising edge with rdy_in high; valid never depends on ready and stays up until taken.
  assign stq_full      = (count_q == CW'(STQ_DEPTH));
  assign stq_pop       = rdy_in && (count_q != '0) && lsb_store_ready_in;
  assign stq_push_req  = accept && is_store;
  assign stq_push      = stq_push_req && (!stq_full || stq_pop);

  assign store_commit_valid_out   = (count_q != '0);
  assign store_commit_lsb_pos_out = store_commit_valid_out ? stq_mem[rd_ptr_q] : '0;
  assign stq_almost_full_out      = (count_q >= CW'(STQ_DEPTH - 1));

  always_ff @(posedge clk_in) begin
    if (stq_push) stq_mem[wr_ptr_q] <= lsb_pos_in;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      stq_overflow_out <= 1'b0;
    end else begin
      if (stq_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (stq_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({stq_push, stq_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (stq_push_req && !stq_push) stq_overflow_out <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      reg_wr_en_out      <= 1'b0;
      reg_wr_rd_out      <= '0;
      reg_wr_data_out    <= '0;
      reg_wr_rob_pos_out <= '0;
      clear_branch_out   <= 1'b0;
      pc_redirect_en_out <= 1'b0;
      pc_redirect_a_out  <= '0;
      retire_cnt_out     <= '0;
    end else if (rdy_in) begin
      reg_wr_en_out      <= wr_req;
      clear_branch_out   <= accept && jump_en_in;
      pc_redirect_en_out <= accept && jump_en_in;
      if (wr_req) begin
        reg_wr_rd_out      <= rd_in;
        reg_wr_data_out    <= res_in;
        reg_wr_rob_pos_out <= rob_pos_in;
      end
      if (accept && jump_en_in) pc_redirect_a_out <= jump_a_in;
      if (accept) retire_cnt_out <= retire_cnt_out + 32'd1;
    end
  end

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: register writes, store queue order/overflow, flush window and reset.
`ifndef COMMIT_UNIT_DEFS
`define COMMIT_UNIT_DEFS
`define InstrIdWidth 6
`define RegIdxWidth  5
`define ROBIdxWidth  4
`define LSBIdxWidth  4
`define WordWidth    32
`define AddrWidth    32
`define JAL   6'd3
`define JALR  6'd4
`define BEQ   6'd5
`define BNE   6'd6
`define BLT   6'd7
`define BGE   6'd8
`define BLTU  6'd9
`define BGEU  6'd10
`define SB    6'd16
`define SH    6'd17
`define SW    6'd18
`define ADDI  6'd19
`define ADD   6'd28
`endif

module tb_commit_unit;

  logic        clk_in, rst_in, rdy_in, rob_to_commit_en_in;
  logic [5:0]  instr_id_in;
  logic [4:0]  rd_in;
  logic [3:0]  rob_pos_in, lsb_pos_in;
  logic [31:0] res_in, jump_a_in;
  logic        jump_en_in, lsb_store_ready_in;
  logic        reg_wr_en_out;
  logic [4:0]  reg_wr_rd_out;
  logic [31:0] reg_wr_data_out;
  logic [3:0]  reg_wr_rob_pos_out;
  logic        store_commit_valid_out;
  logic [3:0]  store_commit_lsb_pos_out;
  logic        clear_branch_out, pc_redirect_en_out;
  logic [31:0] pc_redirect_a_out;
  logic        stq_almost_full_out, stq_overflow_out;
  logic [31:0] retire_cnt_out;
  logic        state_dbg_out;

  int n_checks = 0;
  int n_err    = 0;
  int exp_retire = 0;
  logic [3:0]  exp_q[$];
  logic [40:0] exp_wr_q[$];

  commit_unit #(.STQ_DEPTH(4), .FLUSH_CYCLES(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rob_to_commit_en_in(rob_to_commit_en_in), .instr_id_in(instr_id_in),
    .rd_in(rd_in), .rob_pos_in(rob_pos_in), .lsb_pos_in(lsb_pos_in), .res_in(res_in),
    .jump_en_in(jump_en_in), .jump_a_in(jump_a_in),
    .reg_wr_en_out(reg_wr_en_out), .reg_wr_rd_out(reg_wr_rd_out),
    .reg_wr_data_out(reg_wr_data_out), .reg_wr_rob_pos_out(reg_wr_rob_pos_out),
    .store_commit_valid_out(store_commit_valid_out),
    .store_commit_lsb_pos_out(store_commit_lsb_pos_out),
    .lsb_store_ready_in(lsb_store_ready_in), .clear_branch_out(clear_branch_out),
    .pc_redirect_en_out(pc_redirect_en_out), .pc_redirect_a_out(pc_redirect_a_out),
    .stq_almost_full_out(stq_almost_full_out), .stq_overflow_out(stq_overflow_out),
    .retire_cnt_out(retire_cnt_out), .state_dbg_out(state_dbg_out)
  );

  // clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #60000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // driver tasks
  task automatic idle();
    rob_to_commit_en_in = 1'b0;
    jump_en_in          = 1'b0;
  endtask

  task automatic pkt(input logic [5:0] id, input logic [4:0] rd, input logic [31:0] res,
                     input logic [3:0] rob, input logic [3:0] lsb, input logic jmp,
                     input logic [31:0] ja, input bit acc);
    rob_to_commit_en_in = 1'b1;
    instr_id_in = id; rd_in = rd; res_in = res; rob_pos_in = rob;
    lsb_pos_in = lsb; jump_en_in = jmp; jump_a_in = ja;
    if (acc) begin
      exp_retire++;
      if (id == `SB || id == `SH || id == `SW) begin
        if (exp_q.size() < 4) exp_q.push_back(lsb);
      end else if (rd != 5'd0 && !(id >= `BEQ && id <= `BGEU)) begin
        exp_wr_q.push_back({rd, res, rob});
      end
    end
  endtask

  // scoreboard side
  task automatic expect_wr(input bit exp, input string tag);
    logic [40:0] e;
    check({tag, "_en"}, {31'd0, reg_wr_en_out}, {31'd0, exp});
    if (exp) begin
      if (exp_wr_q.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL %s_q: observed=empty expected=entry", tag);
      end else begin
        e = exp_wr_q.pop_front();
        check({tag, "_rd"},   {27'd0, reg_wr_rd_out},      {27'd0, e[40:36]});
        check({tag, "_data"}, reg_wr_data_out,             e[35:4]);
        check({tag, "_tag"},  {28'd0, reg_wr_rob_pos_out}, {28'd0, e[3:0]});
      end
    end
  endtask

  task automatic drain_head(input string tag);
    check({tag, "_valid"}, {31'd0, store_commit_valid_out}, 32'd1);
    if (exp_q.size() != 0)
      check({tag, "_pos"}, {28'd0, store_commit_lsb_pos_out}, {28'd0, exp_q.pop_front()});
  endtask

  task automatic drain_all(input string tag);
    lsb_store_ready_in = 1'b1;
    for (int k = 0; k < 8 && exp_q.size() != 0; k++) begin
      drain_head(tag);
      tick();
    end
    check({tag, "_left"}, exp_q.size(), 32'd0);
    check({tag, "_empty"}, {31'd0, store_commit_valid_out}, 32'd0);
    lsb_store_ready_in = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},  {31'd0, reg_wr_en_out}, 32'd0);
    check({tag, "_wr_rd"},  {27'd0, reg_wr_rd_out}, 32'd0);
    check({tag, "_wr_dat"}, reg_wr_data_out, 32'd0);
    check({tag, "_wr_tag"}, {28'd0, reg_wr_rob_pos_out}, 32'd0);
    check({tag, "_sq_v"},   {31'd0, store_commit_valid_out}, 32'd0);
    check({tag, "_sq_pos"}, {28'd0, store_commit_lsb_pos_out}, 32'd0);
    check({tag, "_clr"},    {31'd0, clear_branch_out}, 32'd0);
    check({tag, "_redir"},  {31'd0, pc_redirect_en_out}, 32'd0);
    check({tag, "_redir_a"}, pc_redirect_a_out, 32'd0);
    check({tag, "_afull"},  {31'd0, stq_almost_full_out}, 32'd0);
    check({tag, "_ovf"},    {31'd0, stq_overflow_out}, 32'd0);
    check({tag, "_retire"}, retire_cnt_out, 32'd0);
    check({tag, "_state"},  {31'd0, state_dbg_out}, 32'd0);
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; lsb_store_ready_in = 1'b0;
    instr_id_in = '0; rd_in = '0; rob_pos_in = '0; lsb_pos_in = '0;
    res_in = '0; jump_a_in = '0;
    idle();
    #3;
    check_reset_outputs("rst0");
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;

    // ALU write, rd=0, branch without jump, hold on rdy low
    pkt(`ADD, 5'd5, 32'h1234, 4'd3, 4'd0, 1'b0, 32'd0, 1'b1);
    tick(); idle();
    expect_wr(1'b1, "alu");
    check("alu_retire", retire_cnt_out, 32'd1);
    tick();
    expect_wr(1'b0, "alu_next");

    pkt(`ADD, 5'd0, 32'h55, 4'd4, 4'd0, 1'b0, 32'd0, 1'b1);
    tick(); idle();
    expect_wr(1'b0, "rd0");
    check("rd0_retire", retire_cnt_out, exp_retire);

    pkt(`BNE, 5'd7, 32'h99, 4'd5, 4'd0, 1'b0, 32'd0, 1'b1);
    tick(); idle();
    expect_wr(1'b0, "bne");
    check("bne_clr", {31'd0, clear_branch_out}, 32'd0);

    pkt(`ADDI, 5'd9, 32'hBEEF, 4'd6, 4'd0, 1'b0, 32'd0, 1'b1);
    tick();
    expect_wr(1'b1, "addi");
    rdy_in = 1'b0;
    pkt(`ADD, 5'd10, 32'h77, 4'd7, 4'd0, 1'b0, 32'd0, 1'b0);
    tick();
    check("hold_en", {31'd0, reg_wr_en_out}, 32'd1);
    check("hold_data", reg_wr_data_out, 32'hBEEF);
    check("hold_retire", retire_cnt_out, exp_retire);
    rdy_in = 1'b1; idle();
    tick();
    expect_wr(1'b0, "after_hold");

    // store queue fill, overflow, simultaneous push/pop at full, ordered drain
    for (int i = 1; i <= 4; i++) begin
      pkt(`SW, 5'd0, 32'd0, 4'(i), 4'(i), 1'b0, 32'd0, 1'b1);
      tick(); idle();
      check($sformatf("fill%0d_afull", i), {31'd0, stq_almost_full_out}, (i >= 3) ? 32'd1 : 32'd0);
      check($sformatf("fill%0d_valid", i), {31'd0, store_commit_valid_out}, 32'd1);
    end
    check("fill_ovf0", {31'd0, stq_overflow_out}, 32'd0);
    pkt(`SB, 5'd0, 32'd0, 4'd5, 4'd5, 1'b0, 32'd0, 1'b1);
    tick(); idle();
    check("ovf_set", {31'd0, stq_overflow_out}, 32'd1);
    check("ovf_retire", retire_cnt_out, exp_retire);
    lsb_store_ready_in = 1'b1;
    drain_head("full_pp");
    pkt(`SH, 5'd0, 32'd0, 4'd6, 4'd6, 1'b0, 32'd0, 1'b1);
    tick(); idle();
    check("full_pp_afull", {31'd0, stq_almost_full_out}, 32'd1);
    drain_all("drain1");
    check("drain1_afull", {31'd0, stq_almost_full_out}, 32'd0);
    check("ovf_sticky", {31'd0, stq_overflow_out}, 32'd1);

    // mispredicted BEQ: pulse, two ignored slots, third accepted
    pkt(`BEQ, 5'd0, 32'd0, 4'd7, 4'd0, 1'b1, 32'h100, 1'b1);
    tick();
    expect_wr(1'b0, "beq");
    check("beq_clr", {31'd0, clear_branch_out}, 32'd1);
    check("beq_redir", {31'd0, pc_redirect_en_out}, 32'd1);
    check("beq_redir_a", pc_redirect_a_out, 32'h100);
    check("beq_state", {31'd0, state_dbg_out}, 32'd1);
    pkt(`ADD, 5'd3, 32'h33, 4'd8, 4'd0, 1'b1, 32'h500, 1'b0);
    tick();
    expect_wr(1'b0, "ign1");
    check("ign1_clr", {31'd0, clear_branch_out}, 32'd0);
    check("ign1_redir", {31'd0, pc_redirect_en_out}, 32'd0);
    pkt(`SW, 5'd0, 32'd0, 4'd9, 4'hA, 1'b0, 32'd0, 1'b0);
    tick();
    expect_wr(1'b0, "ign2");
    check("ign2_sq", {31'd0, store_commit_valid_out}, 32'd0);
    check("ign2_state", {31'd0, state_dbg_out}, 32'd0);
    pkt(`ADD, 5'd4, 32'hAB, 4'd9, 4'd0, 1'b0, 32'd0, 1'b1);
    tick(); idle();
    expect_wr(1'b1, "post_flush");
    check("post_flush_retire", retire_cnt_out, exp_retire);
    check("post_flush_redir_a", pc_redirect_a_out, 32'h100);

    // redirecting JALR writes rd in the flush cycle; queued stores survive the flush
    pkt(`SW, 5'd0, 32'd0, 4'd1, 4'd7, 1'b0, 32'd0, 1'b1);
    tick();
    pkt(`SW, 5'd0, 32'd0, 4'd2, 4'd8, 1'b0, 32'd0, 1'b1);
    tick();
    pkt(`JALR, 5'd1, 32'h44, 4'd10, 4'd0, 1'b1, 32'h200, 1'b1);
    tick(); idle();
    expect_wr(1'b1, "jalr");
    check("jalr_clr", {31'd0, clear_branch_out}, 32'd1);
    check("jalr_redir_a", pc_redirect_a_out, 32'h200);
    tick(); tick();
    check("jalr_state", {31'd0, state_dbg_out}, 32'd0);
    drain_all("drain2");
    check("jalr_retire", retire_cnt_out, exp_retire);

    // reset in the middle of FLUSH with two queued stores
    pkt(`SW, 5'd0, 32'd0, 4'd3, 4'd2, 1'b0, 32'd0, 1'b1);
    tick();
    pkt(`SW, 5'd0, 32'd0, 4'd4, 4'd3, 1'b0, 32'd0, 1'b1);
    tick();
    pkt(`BEQ, 5'd0, 32'd0, 4'd5, 4'd0, 1'b1, 32'h300, 1'b1);
    tick(); idle();
    check("pre_rst_state", {31'd0, state_dbg_out}, 32'd1);
    check("pre_rst_sq", {31'd0, store_commit_valid_out}, 32'd1);
    #2 rst_in = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    exp_q.delete(); exp_wr_q.delete(); exp_retire = 0;
    rst_in = 1'b1;
    pkt(`ADD, 5'd6, 32'h66, 4'd11, 4'd0, 1'b0, 32'd0, 1'b1);
    tick(); idle();
    expect_wr(1'b1, "post_rst");
    check("post_rst_retire", retire_cnt_out, 32'd1);
    check("post_rst_sq", {31'd0, store_commit_valid_out}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
